// File: rtl/uart_rx_sync_if.sv
// Bundle of the serial line, consumer acknowledge and received-byte/flag outputs
// between the UART receiver and the command layer.
interface uart_rx_sync_if #(
  parameter int unsigned DATA_W = 8
);
  logic              serial_rx;
  logic              clear_interrupt;
  logic [DATA_W-1:0] uart_data;
  logic              rx_interrupt;
  logic              framing_error;
  logic              overrun;

  // Receiver side
  modport slave (
    input  serial_rx,
    input  clear_interrupt,
    output uart_data,
    output rx_interrupt,
    output framing_error,
    output overrun
  );

  // Line driver / consumer side
  modport master (
    output serial_rx,
    output clear_interrupt,
    input  uart_data,
    input  rx_interrupt,
    input  framing_error,
    input  overrun
  );
endinterface

// File: rtl/uart_rx_sync.sv
// 8N1 UART receiver with a 2-flop input synchroniser and sticky rx_interrupt,
// framing_error and overrun flags acknowledged by clear_interrupt.
module uart_rx_sync #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned DATA_W    = 8
) (
  input logic          clk,
  input logic          rst,
  uart_rx_sync_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e state_q, state_d;

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic rx_prev_q, rx_prev_d;

  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rx_int_q, rx_int_d;
  logic              fe_q, fe_d;
  logic              ovr_q, ovr_d;

  logic rx_s;
  logic fall_edge;
  logic baud_done;
  logic half_done;
  logic stop_ok;
  logic stop_bad;

  assign rx_s      = sync2_q;
  assign fall_edge = rx_prev_q & ~rx_s;
  assign baud_done = (baud_q == BAUD_LAST);
  assign half_done = (baud_q == HALF_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fall_edge) begin
          state_d = START;
        end
      end
      START: begin
        // A line that is high again at mid-bit was a glitch, not a start bit
        if (half_done) begin
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_done && (idx_q == IDX_LAST)) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (baud_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and flag logic
  always_comb begin
    sync1_d   = bus.serial_rx;
    sync2_d   = sync1_q;
    rx_prev_d = rx_s;
    baud_d    = baud_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        idx_d  = '0;
      end
      START: begin
        if (half_done) begin
          baud_d = '0;
          idx_d  = '0;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          idx_d   = idx_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d   = '0;
          stop_ok  = rx_s;
          stop_bad = ~rx_s;
        end
      end
      default: begin
        baud_d = '0;
        idx_d  = '0;
      end
    endcase

    data_d = stop_ok ? shift_q : data_q;

    // Completion beats a coincident acknowledge; an acknowledged byte is not an overrun
    rx_int_d = rx_int_q;
    fe_d     = fe_q;
    ovr_d    = ovr_q;
    if (bus.clear_interrupt) begin
      rx_int_d = 1'b0;
      fe_d     = 1'b0;
      ovr_d    = 1'b0;
    end
    if (stop_ok) begin
      rx_int_d = 1'b1;
    end
    if (stop_ok && rx_int_q && !bus.clear_interrupt) begin
      ovr_d = 1'b1;
    end
    if (stop_bad) begin
      fe_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      baud_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rx_int_q  <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      rx_prev_q <= rx_prev_d;
      baud_q    <= baud_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rx_int_q  <= rx_int_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.uart_data     = data_q;
  assign bus.rx_interrupt  = rx_int_q;
  assign bus.framing_error = fe_q;
  assign bus.overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx_sync.sv
// Directed bench for uart_rx_sync at 16 clocks per bit.
module tb_uart_rx_sync;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  uart_rx_sync_if #(.DATA_W(8)) bus ();

  uart_rx_sync #(
    .CLK_FREQ (1600),
    .BAUD_RATE(100),
    .DATA_W   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line level during cycle c of a frame starting at c = 0, 16 clocks per bit
  function automatic logic line_val(input logic [7:0] d, input logic stop, input int c);
    int b;
    b = c / 16;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9) return stop;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full 160-clock frame; rise = edges after start edge when rx_interrupt went 0->1
  task automatic run_frame(input logic [7:0] d, input logic stop, input int clr_cycle,
                           output int rise);
    logic prev;
    rise = -1;
    for (int c = 0; c < 160; c++) begin
      prev = bus.rx_interrupt;
      bus.serial_rx       = line_val(d, stop, c);
      bus.clear_interrupt = (c == clr_cycle);
      tick();
      if (rise < 0 && !prev && bus.rx_interrupt) rise = c + 1;
    end
    bus.serial_rx       = 1'b1;
    bus.clear_interrupt = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_interrupt = 1'b1;
    tick();
    bus.clear_interrupt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.serial_rx = 1'b1;
    bus.clear_interrupt = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.uart_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.uart_data); end
    checks++; if (bus.rx_interrupt !== 1'b0) begin errors++; $display("FAIL reset_rxint: got %b expected 0", bus.rx_interrupt); end
    checks++; if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", bus.framing_error); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", bus.overrun); end
  endtask

  task automatic test_basic_frame();
    int rise;
    run_frame(8'hFE, 1'b1, -1, rise);
    checks++; if (rise < 154 || rise > 156) begin errors++; $display("FAIL basic_latency: got %0d expected 155+-1", rise); end
    checks++; if (bus.uart_data !== 8'hFE) begin errors++; $display("FAIL basic_data: got %0h expected fe", bus.uart_data); end
    checks++; if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL basic_fe: got %b expected 0", bus.framing_error); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL basic_ovr: got %b expected 0", bus.overrun); end
    pulse_clear();
    checks++; if (bus.rx_interrupt !== 1'b0) begin errors++; $display("FAIL basic_clear: got %b expected 0", bus.rx_interrupt); end
    checks++; if (bus.uart_data !== 8'hFE) begin errors++; $display("FAIL basic_data_kept: got %0h expected fe", bus.uart_data); end
  endtask

  task automatic test_glitch();
    int bad_int, bad_fe, bad_data;
    bad_int = 0; bad_fe = 0; bad_data = 0;
    bus.serial_rx = 1'b0;
    repeat (4) tick();
    bus.serial_rx = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (bus.rx_interrupt !== 1'b0) bad_int++;
      if (bus.framing_error !== 1'b0) bad_fe++;
      if (bus.uart_data !== 8'hFE) bad_data++;
    end
    checks++; if (bad_int != 0) begin errors++; $display("FAIL glitch_rxint: got %0d bad cycles expected 0", bad_int); end
    checks++; if (bad_fe != 0) begin errors++; $display("FAIL glitch_fe: got %0d bad cycles expected 0", bad_fe); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL glitch_data: got %0d bad cycles expected 0", bad_data); end
  endtask

  task automatic test_framing_error();
    int rise;
    run_frame(8'h55, 1'b0, -1, rise);
    tick();
    checks++; if (bus.framing_error !== 1'b1) begin errors++; $display("FAIL frame_fe: got %b expected 1", bus.framing_error); end
    checks++; if (bus.rx_interrupt !== 1'b0) begin errors++; $display("FAIL frame_rxint: got %b expected 0", bus.rx_interrupt); end
    checks++; if (bus.uart_data !== 8'hFE) begin errors++; $display("FAIL frame_data: got %0h expected fe", bus.uart_data); end
    pulse_clear();
    checks++; if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL frame_clear: got %b expected 0", bus.framing_error); end
  endtask

  task automatic test_back_to_back();
    int rise;
    run_frame(8'h01, 1'b1, -1, rise);
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_first_ovr: got %b expected 0", bus.overrun); end
    run_frame(8'h02, 1'b1, -1, rise);
    checks++; if (bus.rx_interrupt !== 1'b1) begin errors++; $display("FAIL b2b_rxint: got %b expected 1", bus.rx_interrupt); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL b2b_ovr: got %b expected 1", bus.overrun); end
    checks++; if (bus.uart_data !== 8'h02) begin errors++; $display("FAIL b2b_data: got %0h expected 02", bus.uart_data); end
    pulse_clear();
    checks++; if ({bus.rx_interrupt, bus.framing_error, bus.overrun} !== 3'b000) begin
      errors++; $display("FAIL b2b_clear: got %b expected 000", {bus.rx_interrupt, bus.framing_error, bus.overrun});
    end
  endtask

  task automatic test_set_clear_collision();
    int rise;
    run_frame(8'h11, 1'b1, -1, rise);
    checks++; if (bus.uart_data !== 8'h11) begin errors++; $display("FAIL coll_first_data: got %0h expected 11", bus.uart_data); end
    run_frame(8'h22, 1'b1, 154, rise);
    checks++; if (rise != -1) begin errors++; $display("FAIL coll_no_drop: got rise at %0d expected none", rise); end
    checks++; if (bus.rx_interrupt !== 1'b1) begin errors++; $display("FAIL coll_rxint: got %b expected 1", bus.rx_interrupt); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL coll_ovr: got %b expected 0", bus.overrun); end
    checks++; if (bus.uart_data !== 8'h22) begin errors++; $display("FAIL coll_data: got %0h expected 22", bus.uart_data); end
    pulse_clear();
  endtask

  task automatic test_reset_mid_frame();
    int rise, bad_int;
    bad_int = 0;
    for (int c = 0; c < 86; c++) begin
      bus.serial_rx = line_val(8'hA5, 1'b1, c);
      tick();
    end
    bus.serial_rx = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bus.uart_data, bus.rx_interrupt, bus.framing_error, bus.overrun} !== 11'h000) begin
      errors++; $display("FAIL midrst_outputs: got %0h/%b%b%b expected 0/000", bus.uart_data,
                        bus.rx_interrupt, bus.framing_error, bus.overrun);
    end
    for (int c = 0; c < 200; c++) begin
      tick();
      if (bus.rx_interrupt !== 1'b0 || bus.framing_error !== 1'b0) bad_int++;
    end
    checks++; if (bad_int != 0) begin errors++; $display("FAIL midrst_quiet: got %0d bad cycles expected 0", bad_int); end
    run_frame(8'h3C, 1'b1, -1, rise);
    checks++; if (rise < 154 || rise > 156) begin errors++; $display("FAIL midrst_latency: got %0d expected 155+-1", rise); end
    checks++; if (bus.uart_data !== 8'h3C) begin errors++; $display("FAIL midrst_data: got %0h expected 3c", bus.uart_data); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_frame();
    test_glitch();
    test_framing_error();
    test_back_to_back();
    test_set_clear_collision();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
